// File: rtl/dmem_handshake_unit_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//  Shared definitions for the data memory handshake unit:
//   - RV32 load/store funct3 encodings
//   - FSM state type
//   - funct3 legality helper for loads and stores
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   // Stores only have signed-agnostic widths; loads add the unsigned variants.
   function automatic logic f3_legal(input logic write, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!write) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/dmem_handshake_unit_if.sv
// -----------------------------------------------------------------------------
// dmem_handshake_unit_if
//  Request/response bus of the data memory.
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_funct3            access width and sign
//   req_addr, req_wdata   byte address and store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    load result and fault flag
//  master = requester (core side), slave = memory unit.
// -----------------------------------------------------------------------------
interface dmem_handshake_unit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_handshake_unit_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
//  Combinational byte-lane logic for one memory word.
//   funct3      in   access width / sign
//   addr_lo     in   byte offset inside the word
//   old_word    in   current contents of the addressed word
//   wdata       in   store data (byte/half in the low bits)
//   store_word  out  old_word with only the addressed bytes replaced
//   load_val    out  addressed bytes, sign- or zero-extended
//   misalign    out  halfword on odd address or word on non-zero offset
// -----------------------------------------------------------------------------
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] old_word,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] store_word,
   output logic [XLEN-1:0] load_val,
   output logic            misalign
);

   logic [4:0]      sh;
   logic [XLEN-1:0] lane;
   logic [XLEN-1:0] shifted;

   always_comb begin
      sh       = 5'd0;
      lane     = '0;
      misalign = 1'b0;
      unique case (funct3)
         F3_B, F3_BU: begin
            sh   = {addr_lo, 3'b000};
            lane = {{(XLEN-8){1'b0}}, 8'hFF};
         end
         F3_H, F3_HU: begin
            sh       = {addr_lo[1], 4'b0000};
            lane     = {{(XLEN-16){1'b0}}, 16'hFFFF};
            misalign = addr_lo[0];
         end
         F3_W: begin
            lane     = '1;
            misalign = |addr_lo;
         end
         default: ;
      endcase

      // Selected lane is moved to bit 0 for loads; the lane mask and the
      // store data are moved up to the lane for stores.
      shifted = old_word >> sh;
      unique case (funct3)
         F3_B:    load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_BU:   load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_H:    load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_HU:   load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_val = shifted;
      endcase

      store_word = (old_word & ~(lane << sh)) | ((wdata << sh) & (lane << sh));
   end

endmodule

// File: rtl/dmem_handshake_unit.sv
// -----------------------------------------------------------------------------
// dmem_handshake_unit
//  Data memory with RV32 byte/half/word loads and stores behind a valid/ready
//  request and response handshake, with WAIT_STATES extra cycles before the
//  access. Misaligned, out-of-range and illegal-funct3 accesses fault with
//  rsp_err=1, rsp_rdata=0 and no memory change.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   bus    slave modport of dmem_handshake_unit_if (req_*/rsp_* handshake)
// -----------------------------------------------------------------------------
module dmem_handshake_unit
   import dmem_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   dmem_handshake_unit_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   dmem_state_t     state, state_next;
   logic [CW-1:0]   cnt;
   logic            ready_q;
   logic [XLEN-1:0] rdata_q;
   logic            err_q;
   logic [XLEN-1:0] mem [DEPTH_WORDS];

   logic            lat_write;
   logic [2:0]      lat_f3;
   logic [XLEN-1:0] lat_addr;
   logic [XLEN-1:0] lat_wdata;

   logic            accept;
   logic            do_access;
   logic            acc_write;
   logic [2:0]      acc_f3;
   logic [XLEN-1:0] acc_addr;
   logic [XLEN-1:0] acc_wdata;
   logic [AW-1:0]   word_idx;
   logic            out_of_range;
   logic            fault;
   logic [XLEN-1:0] store_word;
   logic [XLEN-1:0] load_val;
   logic            misalign;

   assign accept = bus.req_valid && ready_q;

   // With zero wait states the access happens on the acceptance edge, so the
   // live request is used; otherwise the latched copy is.
   assign acc_write = (state == IDLE) ? bus.req_write  : lat_write;
   assign acc_f3    = (state == IDLE) ? bus.req_funct3 : lat_f3;
   assign acc_addr  = (state == IDLE) ? bus.req_addr   : lat_addr;
   assign acc_wdata = (state == IDLE) ? bus.req_wdata  : lat_wdata;

   assign do_access = ((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && (cnt == '0));

   assign word_idx     = acc_addr[AW+1:2];
   assign out_of_range = |(acc_addr >> (AW + 2));
   assign fault        = misalign || out_of_range || !f3_legal(acc_write, acc_f3);

   dmem_lane_align #(.XLEN(XLEN)) u_lane_align (
      .funct3     (acc_f3),
      .addr_lo    (acc_addr[1:0]),
      .old_word   (mem[word_idx]),
      .wdata      (acc_wdata),
      .store_word (store_word),
      .load_val   (load_val),
      .misalign   (misalign)
   );

   always_comb begin
      state_next    = state;
      bus.rsp_valid = (state == RESP);
      unique case (state)
         IDLE: if (accept) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT: if (cnt == '0) state_next = RESP;
         RESP: if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // req_ready is registered from the next state so it is high exactly in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q <= 1'b0;
         cnt     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         ready_q <= (state_next == IDLE);
         if ((state == IDLE) && accept) begin
            cnt <= CNT_INIT;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (do_access) begin
            rdata_q <= (fault || acc_write) ? '0 : load_val;
            err_q   <= fault;
            if (acc_write && !fault) begin
               mem[word_idx] <= store_word;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_write <= bus.req_write;
         lat_f3    <= bus.req_funct3;
         lat_addr  <= bus.req_addr;
         lat_wdata <= bus.req_wdata;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_handshake_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_handshake_unit
//  Scoreboard bench for dmem_handshake_unit. Two instances: index 0 with
//  WAIT_STATES=0 and index 1 with WAIT_STATES=3, both DEPTH_WORDS=64.
// -----------------------------------------------------------------------------
module tb_dmem_handshake_unit;
   import dmem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  [2];
   logic        vld  [2];
   logic        wr   [2];
   logic [2:0]  f3   [2];
   logic [31:0] addr [2];
   logic [31:0] wd   [2];
   logic        rrdy [2];
   logic        rdy  [2];
   logic        rv   [2];
   logic [31:0] rd   [2];
   logic        er   [2];

   int total = 0;
   int bad   = 0;

   logic [32:0] q0 [$];
   logic [32:0] q1 [$];
   logic [32:0] e0, e1;

   dmem_handshake_unit_if #(.XLEN(32)) if0 ();
   dmem_handshake_unit_if #(.XLEN(32)) if1 ();

   assign if0.req_valid  = vld[0];
   assign if0.req_write  = wr[0];
   assign if0.req_funct3 = f3[0];
   assign if0.req_addr   = addr[0];
   assign if0.req_wdata  = wd[0];
   assign if0.rsp_ready  = rrdy[0];
   assign rdy[0] = if0.req_ready;
   assign rv[0]  = if0.rsp_valid;
   assign rd[0]  = if0.rsp_rdata;
   assign er[0]  = if0.rsp_err;

   assign if1.req_valid  = vld[1];
   assign if1.req_write  = wr[1];
   assign if1.req_funct3 = f3[1];
   assign if1.req_addr   = addr[1];
   assign if1.req_wdata  = wd[1];
   assign if1.rsp_ready  = rrdy[1];
   assign rdy[1] = if1.req_ready;
   assign rv[1]  = if1.rsp_valid;
   assign rd[1]  = if1.rsp_rdata;
   assign er[1]  = if1.rsp_err;

   dmem_handshake_unit #(.XLEN(32), .DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
      .clk   (clk),
      .reset (rst[0]),
      .bus   (if0.slave)
   );

   dmem_handshake_unit #(.XLEN(32), .DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
      .clk   (clk),
      .reset (rst[1]),
      .bus   (if1.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Monitors: pop one expectation per completed response handshake.
   always @(negedge clk) begin
      if (rv[0] === 1'b1 && rrdy[0]) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp0 unexpected: got 0x%08h want no response", rd[0]);
         end else begin
            e0 = q0.pop_front();
            check("rsp0 rdata", rd[0], e0[31:0]);
            check("rsp0 err", {31'b0, er[0]}, {31'b0, e0[32]});
         end
      end
   end

   always @(negedge clk) begin
      if (rv[1] === 1'b1 && rrdy[1]) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp3 unexpected: got 0x%08h want no response", rd[1]);
         end else begin
            e1 = q1.pop_front();
            check("rsp3 rdata", rd[1], e1[31:0]);
            check("rsp3 err", {31'b0, er[1]}, {31'b0, e1[32]});
         end
      end
   end

   // One request: push the expectation, wait for acceptance, then measure the
   // latency to rsp_valid and wait for the response to complete.
   task automatic issue(input int i, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_e,
                        input int exp_lat, input string name);
      int n;
      int lat;
      if (i == 0) q0.push_back({exp_e, exp_rd});
      else        q1.push_back({exp_e, exp_rd});
      @(negedge clk);
      vld[i] = 1'b1; wr[i] = w; f3[i] = f; addr[i] = a; wd[i] = d;
      n = 0;
      while (!rdy[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[i]) begin
         total++; bad++;
         $display("FAIL %s accept timeout: got req_ready=0 want 1", name);
         vld[i] = 1'b0;
         return;
      end
      @(posedge clk);
      #1 vld[i] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rv[i] && lat < 50);
      check({name, " latency"}, lat, exp_lat);
      n = 0;
      while (rv[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; vld[i] = 1'b0; wr[i] = 1'b0; f3[i] = 3'b000;
         addr[i] = '0; wd[i] = '0; rrdy[i] = 1'b1;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("reset req_ready", {31'b0, rdy[0]}, 32'd0);
      check("reset rsp_valid", {31'b0, rv[0]}, 32'd0);
      check("reset rsp_rdata", rd[0], 32'd0);
      check("reset rsp_err", {31'b0, er[0]}, 32'd0);
      check("reset3 req_ready", {31'b0, rdy[1]}, 32'd0);
      rst[0] = 1'b1; rst[1] = 1'b1;
      #1 check("release req_ready before edge", {31'b0, rdy[0]}, 32'd0);
      @(posedge clk);
      #1;
      check("release req_ready", {31'b0, rdy[0]}, 32'd1);
      check("release3 req_ready", {31'b0, rdy[1]}, 32'd1);

      // Word store/load, both wait-state settings
      issue(0, 1'b1, F3_W, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 1, "SW 08");
      issue(0, 1'b0, F3_W, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 1, "LW 08");
      issue(1, 1'b1, F3_W, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 4, "ws3 SW 08");
      issue(1, 1'b0, F3_W, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 4, "ws3 LW 08");

      // Byte/half lanes
      issue(0, 1'b1, F3_B,  32'h09, 32'h00000080, 32'h0, 1'b0, 1, "SB 09");
      issue(0, 1'b0, F3_B,  32'h09, 32'h0, 32'hFFFFFF80, 1'b0, 1, "LB 09");
      issue(0, 1'b0, F3_BU, 32'h09, 32'h0, 32'h00000080, 1'b0, 1, "LBU 09");
      issue(0, 1'b0, F3_W,  32'h08, 32'h0, 32'hDEAD80EF, 1'b0, 1, "LW 08 merged");
      issue(0, 1'b0, F3_H,  32'h0A, 32'h0, 32'hFFFFDEAD, 1'b0, 1, "LH 0A");
      issue(0, 1'b0, F3_HU, 32'h0A, 32'h0, 32'h0000DEAD, 1'b0, 1, "LHU 0A");
      issue(0, 1'b1, F3_H,  32'h0E, 32'hABCD7FFF, 32'h0, 1'b0, 1, "SH 0E");
      issue(0, 1'b0, F3_W,  32'h0C, 32'h0, 32'h7FFF0000, 1'b0, 1, "LW 0C");
      issue(0, 1'b1, F3_W,  32'hFC, 32'h11223344, 32'h0, 1'b0, 1, "SW FC last");
      issue(0, 1'b0, F3_B,  32'hFF, 32'h0, 32'h00000011, 1'b0, 1, "LB FF last");

      // Faults
      issue(0, 1'b0, F3_H,   32'h03, 32'h0, 32'h0, 1'b1, 1, "LH 03 misalign");
      issue(0, 1'b1, F3_W,   32'h06, 32'h12345678, 32'h0, 1'b1, 1, "SW 06 misalign");
      issue(0, 1'b0, F3_W,   32'h04, 32'h0, 32'h0, 1'b0, 1, "LW 04 unchanged");
      issue(0, 1'b0, F3_W,   32'h100, 32'h0, 32'h0, 1'b1, 1, "LW 100 range");
      issue(0, 1'b0, 3'b011, 32'h08, 32'h0, 32'h0, 1'b1, 1, "LD f3 011");
      issue(0, 1'b1, F3_BU,  32'h08, 32'h0, 32'h0, 1'b1, 1, "store f3 100");
      issue(0, 1'b0, F3_W,   32'h08, 32'h0, 32'hDEAD80EF, 1'b0, 1, "LW 08 after faults");

      // Backpressure: response held while a second request waits
      q0.push_back({1'b0, 32'hDEAD80EF});
      q0.push_back({1'b0, 32'h000000EF});
      @(negedge clk);
      rrdy[0] = 1'b0;
      vld[0] = 1'b1; wr[0] = 1'b0; f3[0] = F3_W; addr[0] = 32'h08; wd[0] = '0;
      n = 0;
      while (!rdy[0] && n < 50) begin @(negedge clk); n++; end
      check("bp first accept ready", {31'b0, rdy[0]}, 32'd1);
      @(posedge clk);
      #1 f3[0] = F3_BU;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp rsp_valid held", {31'b0, rv[0]}, 32'd1);
         check("bp rsp_rdata held", rd[0], 32'hDEAD80EF);
         check("bp rsp_err held", {31'b0, er[0]}, 32'd0);
         check("bp req_ready low", {31'b0, rdy[0]}, 32'd0);
      end
      @(posedge clk);
      #1 rrdy[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!rdy[0] && n < 50);
      check("bp second accept ready", {31'b0, rdy[0]}, 32'd1);
      @(posedge clk);
      #1 vld[0] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rv[0] && n < 50);
      check("bp second rsp_valid", {31'b0, rv[0]}, 32'd1);
      while (rv[0] && n < 100) begin @(negedge clk); n++; end

      // Reset during wait states aborts the store
      @(negedge clk);
      vld[1] = 1'b1; wr[1] = 1'b1; f3[1] = F3_W; addr[1] = 32'h10; wd[1] = 32'hA5A5A5A5;
      n = 0;
      while (!rdy[1] && n < 50) begin @(negedge clk); n++; end
      check("abort accept ready", {31'b0, rdy[1]}, 32'd1);
      @(posedge clk);
      #1 vld[1] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst[1] = 1'b0;
      #1;
      check("abort rsp_valid", {31'b0, rv[1]}, 32'd0);
      check("abort req_ready", {31'b0, rdy[1]}, 32'd0);
      repeat (2) @(negedge clk);
      rst[1] = 1'b1;
      @(posedge clk);
      issue(1, 1'b0, F3_W, 32'h10, 32'h0, 32'h00000000, 1'b0, 4, "ws3 LW 10 after abort");
      issue(1, 1'b0, F3_W, 32'h08, 32'h0, 32'h00000000, 1'b0, 4, "ws3 LW 08 cleared");

      repeat (3) @(negedge clk);
      check("q0 drained", q0.size(), 32'd0);
      check("q3 drained", q1.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
